// File: rtl/tx_sched_arbiter_pkg.sv
// Shared TX scheduler definitions: command width, header encodings and arbiter FSM states.
package tx_sched_arbiter_pkg;

    localparam int unsigned TX_CMD_BITS = 8;

    localparam logic [1:0] TX_HEADER_WRITE = 2'b00;
    localparam logic [1:0] TX_HEADER_READ  = 2'b01;
    localparam logic [1:0] TX_HEADER_RESP  = 2'b10;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tx_sched_arbiter_if.sv
// Bundle of request, TX command, RX attribution and status signals around the arbiter.
interface tx_sched_arbiter_if
    import tx_sched_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CMD_BITS        = TX_CMD_BITS
);
    localparam int unsigned OWNER_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_CH-1:0]          req_valid;
    logic [NUM_CH*CMD_BITS-1:0] req_cmd;
    logic [NUM_CH-1:0]          req_reply_wanted;
    logic [NUM_CH-1:0]          req_reserve;
    logic [NUM_CH-1:0]          req_started;
    logic                       tx_command_valid;
    logic [CMD_BITS-1:0]        tx_command;
    logic                       tx_command_started;
    logic                       rx_started;
    logic                       rx_done;
    logic [OWNER_W-1:0]         rx_owner;
    logic                       rx_owner_valid;
    logic                       rx_orphan;
    logic [CNT_W-1:0]           outstanding;
    logic                       full;

    modport master (
        output req_valid, req_cmd, req_reply_wanted, req_reserve,
        output tx_command_started, rx_started, rx_done,
        input  req_started, tx_command_valid, tx_command,
        input  rx_owner, rx_owner_valid, rx_orphan, outstanding, full
    );

    modport slave (
        input  req_valid, req_cmd, req_reply_wanted, req_reserve,
        input  tx_command_started, rx_started, rx_done,
        output req_started, tx_command_valid, tx_command,
        output rx_owner, rx_owner_valid, rx_orphan, outstanding, full
    );

endinterface

// File: rtl/tx_reply_fifo.sv
// Issue-order FIFO of channel ids for reads awaiting an RX reply; push and pop may coincide.
module tx_reply_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic [CntW-1:0]  count,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/tx_sched_arbiter.sv
// Round-robin arbiter of per-channel TX commands with optional path lock and in-order
// attribution of RX replies to the channel that issued the read.
module tx_sched_arbiter
    import tx_sched_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CMD_BITS        = TX_CMD_BITS
) (
    input logic               clk,
    input logic               reset,
    tx_sched_arbiter_if.slave bus
);
    localparam int unsigned OwnerW = $clog2(NUM_CH);
    localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e        state_q, state_d;
    logic [OwnerW-1:0] grant_q, grant_d;
    logic [OwnerW-1:0] rr_ptr_q, rr_ptr_d;
    logic [OwnerW-1:0] lock_owner_q, lock_owner_d;
    logic              lock_active_q, lock_active_d;
    logic [OwnerW-1:0] rx_owner_q, rx_owner_d;
    logic              rx_owner_valid_q, rx_owner_valid_d;

    logic [NUM_CH-1:0] eligible;
    logic [OwnerW-1:0] pick, idx;
    logic              found;
    logic              issue_done, push, pop;
    logic [OwnerW-1:0] fifo_head;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_empty, fifo_full;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eligible[i] = bus.req_valid[i] && !(bus.req_reply_wanted[i] && fifo_full) &&
                          (!lock_active_q || lock_owner_q == OwnerW'(i));
        end
    end

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx = OwnerW'((32'(rr_ptr_q) + off) % NUM_CH);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign issue_done = (state_q == StIssue) && bus.tx_command_started;
    assign push       = issue_done && bus.req_reply_wanted[grant_q];
    assign pop        = bus.rx_started && !fifo_empty;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d  = StIssue;
                    grant_d  = pick;
                    rr_ptr_d = pick;
                end
            end
            StIssue: begin
                if (bus.tx_command_started) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.tx_command_valid = (state_q == StIssue);
        bus.tx_command       = '0;
        bus.req_started      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_q == OwnerW'(i)) begin
                bus.tx_command = bus.req_cmd[i*CMD_BITS +: CMD_BITS];
            end
        end
        if (issue_done) begin
            bus.req_started[grant_q] = 1'b1;
        end
    end

    // A fresh reservation wins over the release of the previous one.
    always_comb begin
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        if (lock_active_q && !bus.req_reserve[lock_owner_q]) begin
            lock_active_d = 1'b0;
        end
        if (issue_done && bus.req_reserve[grant_q]) begin
            lock_active_d = 1'b1;
            lock_owner_d  = grant_q;
        end
    end

    // rx_done closes the old message, so a coincident pop leaves the owner valid.
    always_comb begin
        rx_owner_d       = rx_owner_q;
        rx_owner_valid_d = rx_owner_valid_q;
        if (bus.rx_done) begin
            rx_owner_valid_d = 1'b0;
        end
        if (pop) begin
            rx_owner_d       = fifo_head;
            rx_owner_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            grant_q          <= '0;
            rr_ptr_q         <= OwnerW'(NUM_CH - 1);
            lock_active_q    <= 1'b0;
            lock_owner_q     <= '0;
            rx_owner_q       <= '0;
            rx_owner_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            rr_ptr_q         <= rr_ptr_d;
            lock_active_q    <= lock_active_d;
            lock_owner_q     <= lock_owner_d;
            rx_owner_q       <= rx_owner_d;
            rx_owner_valid_q <= rx_owner_valid_d;
        end
    end

    tx_reply_fifo #(
        .Depth(MAX_OUTSTANDING),
        .Width(OwnerW)
    ) u_reply_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(grant_q),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.rx_owner       = rx_owner_q;
    assign bus.rx_owner_valid = rx_owner_valid_q;
    assign bus.rx_orphan      = bus.rx_started && fifo_empty;
    assign bus.outstanding    = fifo_count;
    assign bus.full           = fifo_full;

endmodule

// File: tb/tb_tx_sched_arbiter.sv
// Directed bench for tx_sched_arbiter with two channels and a two-deep reply FIFO.
module tb_tx_sched_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tx_sched_arbiter_if #(.NUM_CH(2), .MAX_OUTSTANDING(2), .CMD_BITS(8)) bus ();

    tx_sched_arbiter #(
        .NUM_CH(2),
        .MAX_OUTSTANDING(2),
        .CMD_BITS(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [7:0] cmd, input logic rw, input logic rsv);
        bus.req_valid[ch]          = 1'b1;
        bus.req_cmd[ch*8 +: 8]     = cmd;
        bus.req_reply_wanted[ch]   = rw;
        bus.req_reserve[ch]        = rsv;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.tx_command_valid && n < 8) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, 32'(bus.tx_command_valid), 32'd1);
    endtask

    // Accept the currently offered command and confirm it came from channel ch.
    task automatic accept(input int ch, input logic [7:0] cmd, input string tag);
        wait_valid(tag);
        check_eq({tag, "_cmd"}, 32'(bus.tx_command), 32'(cmd));
        bus.tx_command_started = 1'b1;
        #1;
        check_eq({tag, "_started"}, 32'(bus.req_started), 32'(1) << ch);
        tick();
        bus.tx_command_started = 1'b0;
    endtask

    task automatic issue(input int ch, input logic [7:0] cmd, input logic rw, input logic rsv,
                         input string tag);
        set_req(ch, cmd, rw, rsv);
        accept(ch, cmd, tag);
        bus.req_valid[ch] = 1'b0;
        #1;
    endtask

    task automatic rx_pulse(input logic start, input logic done);
        bus.rx_started = start;
        bus.rx_done    = done;
        tick();
        bus.rx_started = 1'b0;
        bus.rx_done    = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid          = '0;
        bus.req_cmd            = '0;
        bus.req_reply_wanted   = '0;
        bus.req_reserve        = '0;
        bus.tx_command_started = 1'b0;
        bus.rx_started         = 1'b0;
        bus.rx_done            = 1'b0;

        tick();
        tick();
        check_eq("rst_valid", 32'(bus.tx_command_valid), 32'd0);
        check_eq("rst_outstanding", 32'(bus.outstanding), 32'd0);
        check_eq("rst_full", 32'(bus.full), 32'd0);
        check_eq("rst_owner_valid", 32'(bus.rx_owner_valid), 32'd0);
        check_eq("rst_owner", 32'(bus.rx_owner), 32'd0);
        check_eq("rst_started", 32'(bus.req_started), 32'd0);
        reset = 1'b0;
        tick();

        // Single reply-wanted request from ch0, accepted three cycles after the offer.
        set_req(0, 8'hA5, 1'b1, 1'b0);
        #1;
        check_eq("single_n_valid", 32'(bus.tx_command_valid), 32'd0);
        tick();
        check_eq("single_n1_valid", 32'(bus.tx_command_valid), 32'd1);
        check_eq("single_cmd", 32'(bus.tx_command), 32'hA5);
        tick();
        tick();
        bus.tx_command_started = 1'b1;
        #1;
        check_eq("single_started", 32'(bus.req_started), 32'd1);
        tick();
        bus.tx_command_started = 1'b0;
        bus.req_valid[0]       = 1'b0;
        #1;
        check_eq("single_outstanding", 32'(bus.outstanding), 32'd1);
        check_eq("single_idle", 32'(bus.tx_command_valid), 32'd0);
        rx_pulse(1'b1, 1'b0);
        check_eq("single_owner", 32'(bus.rx_owner), 32'd0);
        check_eq("single_owner_valid", 32'(bus.rx_owner_valid), 32'd1);
        check_eq("single_drained", 32'(bus.outstanding), 32'd0);
        rx_pulse(1'b0, 1'b1);
        check_eq("single_done", 32'(bus.rx_owner_valid), 32'd0);

        // Both channels request continuously; last grant was ch0, so ch1 goes first.
        set_req(0, 8'h10, 1'b0, 1'b0);
        set_req(1, 8'h21, 1'b0, 1'b0);
        accept(1, 8'h21, "rr0");
        accept(0, 8'h10, "rr1");
        accept(1, 8'h21, "rr2");
        accept(0, 8'h10, "rr3");
        bus.req_valid = '0;
        #1;

        // Two reads fill the FIFO and hold back a third reply-wanted request.
        issue(1, 8'h31, 1'b1, 1'b0, "full_a");
        issue(0, 8'h40, 1'b1, 1'b0, "full_b");
        check_eq("full_outstanding", 32'(bus.outstanding), 32'd2);
        check_eq("full_flag", 32'(bus.full), 32'd1);
        set_req(1, 8'h32, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("full_blocked", 32'(bus.tx_command_valid), 32'd0);
        end
        bus.rx_started = 1'b1;
        #1;
        check_eq("full_no_orphan", 32'(bus.rx_orphan), 32'd0);
        rx_pulse(1'b1, 1'b0);
        check_eq("full_pop_owner", 32'(bus.rx_owner), 32'd1);
        check_eq("full_cleared", 32'(bus.full), 32'd0);
        check_eq("full_pop_count", 32'(bus.outstanding), 32'd1);
        accept(1, 8'h32, "full_c");
        bus.req_valid[1] = 1'b0;
        #1;
        check_eq("full_again", 32'(bus.full), 32'd1);

        // FIFO holds ch0 then ch1; start and done coincide on the next message.
        rx_pulse(1'b1, 1'b1);
        check_eq("ord_owner0", 32'(bus.rx_owner), 32'd0);
        check_eq("ord_valid0", 32'(bus.rx_owner_valid), 32'd1);
        check_eq("ord_count0", 32'(bus.outstanding), 32'd1);

        // Push and pop in one cycle leave the count unchanged.
        set_req(1, 8'h33, 1'b1, 1'b0);
        wait_valid("pp");
        check_eq("pp_cmd", 32'(bus.tx_command), 32'h33);
        bus.tx_command_started = 1'b1;
        bus.rx_started         = 1'b1;
        tick();
        bus.tx_command_started = 1'b0;
        bus.rx_started         = 1'b0;
        bus.req_valid[1]       = 1'b0;
        #1;
        check_eq("pp_count", 32'(bus.outstanding), 32'd1);
        check_eq("pp_owner", 32'(bus.rx_owner), 32'd1);
        rx_pulse(1'b0, 1'b1);
        check_eq("ord_done", 32'(bus.rx_owner_valid), 32'd0);
        rx_pulse(1'b1, 1'b0);
        check_eq("ord_owner2", 32'(bus.rx_owner), 32'd1);
        check_eq("ord_valid2", 32'(bus.rx_owner_valid), 32'd1);
        check_eq("ord_empty", 32'(bus.outstanding), 32'd0);

        // RX start with nothing outstanding is an orphan and changes nothing.
        bus.rx_started = 1'b1;
        #1;
        check_eq("orphan_pulse", 32'(bus.rx_orphan), 32'd1);
        tick();
        bus.rx_started = 1'b0;
        #1;
        check_eq("orphan_clear", 32'(bus.rx_orphan), 32'd0);
        check_eq("orphan_count", 32'(bus.outstanding), 32'd0);
        check_eq("orphan_valid", 32'(bus.rx_owner_valid), 32'd1);
        check_eq("orphan_owner", 32'(bus.rx_owner), 32'd1);

        // ch1 reserves the path; ch0 waits until the reservation is dropped.
        issue(1, 8'h51, 1'b0, 1'b1, "lock_a");
        set_req(0, 8'h60, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("lock_blocked", 32'(bus.tx_command_valid), 32'd0);
        end
        issue(1, 8'h52, 1'b0, 1'b1, "lock_b");
        bus.req_reserve[1] = 1'b0;
        accept(0, 8'h60, "lock_rel");
        bus.req_valid[0] = 1'b0;
        #1;

        // Reset while a command is on offer with two reads outstanding.
        issue(0, 8'h70, 1'b1, 1'b0, "rst_a");
        issue(1, 8'h71, 1'b1, 1'b0, "rst_b");
        check_eq("rst_pre_count", 32'(bus.outstanding), 32'd2);
        set_req(1, 8'h72, 1'b0, 1'b0);
        wait_valid("rst_issue");
        reset = 1'b1;
        tick();
        check_eq("rst_mid_valid", 32'(bus.tx_command_valid), 32'd0);
        check_eq("rst_mid_count", 32'(bus.outstanding), 32'd0);
        check_eq("rst_mid_full", 32'(bus.full), 32'd0);
        check_eq("rst_mid_owner_valid", 32'(bus.rx_owner_valid), 32'd0);
        check_eq("rst_mid_owner", 32'(bus.rx_owner), 32'd0);
        bus.req_valid = '0;
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
